// File: rtl/fetch_port.sv
// Instruction-port responder: one-entry holding buffer in front of a req/ack
// instruction memory bus, with flush handling and a request timeout.
module fetch_port #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_address,
  output logic [31:0] fetch_data,
  output logic        fetch_ready,
  output logic        fetch_error,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_rdata
);

  // Counter only needs to reach TIMEOUT_CYCLES-1: the timeout fires on that cycle.
  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit              TO_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {IDLE, REQ} state_e;

  state_e             state_q, state_d;
  logic               buf_valid_q, buf_valid_d;
  logic [29:0]        buf_addr_q, buf_addr_d;
  logic [31:0]        buf_data_q, buf_data_d;
  logic               buf_err_q, buf_err_d;
  logic               mem_req_q, mem_req_d;
  logic [29:0]        mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               discard_q, discard_d;

  logic hit;
  logic timeout;
  logic resp;
  logic fill_err;
  logic unused_addr_bits;

  assign unused_addr_bits = ^fetch_address[1:0];

  assign hit      = buf_valid_q && (buf_addr_q == fetch_address[31:2]);
  assign timeout  = TO_EN && (cnt_q == CNT_LAST);
  assign resp     = mem_ack || mem_err || timeout;
  // A timeout with no ack on the same cycle fills as a bus error.
  assign fill_err = mem_err || !mem_ack;

  assign fetch_ready = hit;
  assign fetch_error = hit && buf_err_q;
  assign fetch_data  = buf_data_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = {mem_addr_q, 2'b00};

  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    buf_err_d   = buf_err_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    cnt_d       = cnt_q;
    discard_d   = discard_q;

    if (flush) begin
      buf_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!flush && !hit) begin
          state_d    = REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_address[31:2];
          cnt_d      = '0;
          discard_d  = 1'b0;
        end
      end
      REQ: begin
        if (resp) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          // A flush seen during or alongside the transaction drops its response.
          if (!discard_q && !flush) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = mem_addr_q;
            buf_data_d  = fill_err ? 32'h0 : mem_rdata;
            buf_err_d   = fill_err;
          end
        end else begin
          cnt_d     = cnt_q + 1'b1;
          discard_d = discard_q | flush;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      buf_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      cnt_q       <= '0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      buf_err_q   <= buf_err_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      cnt_q       <= cnt_d;
      discard_q   <= discard_d;
    end
  end

endmodule
